// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve countdown, play, point pause and game over, all paced by frame_tick.
// Drives the ball-logic hold/run/serve-direction controls and keeps both score counters.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_rst,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               winner,
  output logic [2:0]         state
);
  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE        = SCORE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               ball_rst_q, ball_rst_d;
  logic               ball_run_q, ball_run_d;
  logic               start_q;
  logic               start_rise;

  assign start_rise = start & ~start_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d   = S_SERVE;
          cnt_d     = '0;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        // A miss always wins over a coincident frame_tick; PLAY does not count frames.
        if (miss_left && miss_right) begin
          serve_dir_d = ~serve_dir_q;
          state_d     = S_POINT;
          cnt_d       = '0;
        end else if (miss_left) begin
          score_r_d   = score_r_q + ONE;
          serve_dir_d = 1'b0;
          cnt_d       = '0;
          state_d     = (score_r_d == WIN) ? S_OVER : S_POINT;
          if (score_r_d == WIN) winner_d = 1'b1;
        end else if (miss_right) begin
          score_l_d   = score_l_q + ONE;
          serve_dir_d = 1'b1;
          cnt_d       = '0;
          state_d     = (score_l_d == WIN) ? S_OVER : S_POINT;
          if (score_l_d == WIN) winner_d = 1'b0;
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            state_d = S_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OVER: begin
        if (start_rise) begin
          state_d     = S_SERVE;
          cnt_d       = '0;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_dir_d = ~winner_q;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        score_l_d   = '0;
        score_r_d   = '0;
        serve_dir_d = 1'b0;
        winner_d    = 1'b0;
      end
    endcase

    // Ball controls follow the state being entered so they line up with state_q.
    ball_rst_d = 1'b1;
    ball_run_d = 1'b0;
    case (state_d)
      S_PLAY:  begin ball_rst_d = 1'b0; ball_run_d = 1'b1; end
      S_POINT: begin ball_rst_d = 1'b0; ball_run_d = 1'b0; end
      default: begin ball_rst_d = 1'b1; ball_run_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      ball_rst_q  <= 1'b1;
      ball_run_q  <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      ball_rst_q  <= ball_rst_d;
      ball_run_q  <= ball_run_d;
      start_q     <= start;
    end
  end

  assign state     = state_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign serve_dir = serve_dir_q;
  assign winner    = winner_q;
  assign ball_rst  = ball_rst_q;
  assign ball_run  = ball_run_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: expected output words are queued as stimulus is
// driven and popped against the DUT one cycle later.
module tb_pong_game_ctrl;
  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic       ball_rst;
  logic       ball_run;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       winner;
  logic [2:0] state;

  pong_game_ctrl #(
    .SERVE_FRAMES(60),
    .POINT_FRAMES(90),
    .WIN_SCORE   (7),
    .SCORE_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .start     (start),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .ball_rst  (ball_rst),
    .ball_run  (ball_run),
    .serve_dir (serve_dir),
    .score_l   (score_l),
    .score_r   (score_r),
    .winner    (winner),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, score_l, score_r, ball_rst, ball_run, serve_dir, winner}
  logic [14:0] obs;
  assign obs = {state, score_l, score_r, ball_rst, ball_run, serve_dir, winner};

  typedef struct {
    string       tag;
    logic [14:0] val;
    logic        chk_win;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic expect_out(input string tag, input int st, input int sl, input int sr,
                            input int br, input int bu, input int sd, input int w, input int cw);
    exp_t e;
    e.tag     = tag;
    e.val     = {3'(st), 4'(sl), 4'(sr), 1'(br), 1'(bu), 1'(sd), 1'(w)};
    e.chk_win = 1'(cw);
    sb.push_back(e);
  endtask

  // winner only carries meaning in OVER and right after reset
  task automatic check_out();
    exp_t        e;
    logic [14:0] m;
    logic [14:0] got;
    logic [14:0] want;
    e    = sb.pop_front();
    m    = e.chk_win ? 15'h7FFF : 15'h7FFE;
    got  = obs & m;
    want = e.val & m;
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $display("FAIL %s observed=%h expected=%h (st,sl,sr,brst,brun,sdir,win)", e.tag, got, want);
      $error("%s: output word differs", e.tag);
    end
  endtask

  task automatic tick(input int ft, input int ml, input int mr);
    frame_tick = 1'(ft);
    miss_left  = 1'(ml);
    miss_right = 1'(mr);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;

    // reset and idle
    tick(0, 0, 0);
    expect_out("reset_hold", 0, 0, 0, 1, 0, 0, 0, 1);
    tick(0, 0, 0);
    check_out();
    rst = 1'b0;
    expect_out("idle_10", 0, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) tick(i == 4 ? 1 : 0, 0, 0);
    check_out();

    // serve countdown; misses in SERVE are ignored
    start = 1'b1;
    expect_out("serve_entry", 1, 0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0);
    check_out();
    start = 1'b0;
    tick(0, 0, 0);
    expect_out("serve_miss_l", 1, 0, 0, 1, 0, 0, 0, 0);
    tick(0, 1, 0);
    check_out();
    expect_out("serve_miss_r", 1, 0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 1);
    check_out();
    expect_out("serve_59", 1, 0, 0, 1, 0, 0, 0, 0);
    frames(59);
    check_out();
    expect_out("serve_60", 2, 0, 0, 0, 1, 0, 0, 0);
    tick(1, 0, 0);
    check_out();
    tick(0, 0, 0);

    // left player scores; coincident frame_tick must not count toward the pause
    expect_out("miss_right", 3, 1, 0, 0, 0, 1, 0, 0);
    tick(1, 0, 1);
    check_out();
    expect_out("point_89", 3, 1, 0, 0, 0, 1, 0, 0);
    frames(89);
    check_out();
    expect_out("point_90", 1, 1, 0, 1, 0, 1, 0, 0);
    frames(1);
    check_out();
    expect_out("play_again", 2, 1, 0, 0, 1, 1, 0, 0);
    frames(60);
    check_out();

    // simultaneous misses toggle serve direction, no score
    expect_out("both_miss", 3, 1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 1);
    check_out();
    frames(150);
    expect_out("both_miss2", 3, 1, 0, 0, 0, 1, 0, 0);
    tick(0, 1, 1);
    check_out();
    frames(150);

    // right player runs the score up to WIN_SCORE
    for (int i = 1; i <= 6; i++) begin
      expect_out($sformatf("miss_left_%0d", i), 3, 1, i, 0, 0, 0, 0, 0);
      tick(0, 1, 0);
      check_out();
      frames(150);
    end
    expect_out("win_right", 4, 1, 7, 1, 0, 0, 1, 1);
    tick(0, 1, 0);
    check_out();
    expect_out("over_hold", 4, 1, 7, 1, 0, 0, 1, 1);
    tick(1, 1, 1);
    check_out();
    start = 1'b1;
    expect_out("rematch", 1, 0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0);
    check_out();
    start = 1'b0;

    // get a score on the board, then reset mid-play with start held high
    expect_out("play_2", 2, 0, 0, 0, 1, 0, 0, 0);
    frames(60);
    check_out();
    expect_out("miss_right_2", 3, 1, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 1);
    check_out();
    expect_out("play_3", 2, 1, 0, 0, 1, 1, 0, 0);
    frames(150);
    check_out();
    start = 1'b1;
    rst   = 1'b1;
    expect_out("rst_in_play", 0, 0, 0, 1, 0, 0, 0, 1);
    tick(0, 0, 0);
    check_out();
    expect_out("rst_start_high", 0, 0, 0, 1, 0, 0, 0, 1);
    tick(0, 0, 0);
    check_out();
    rst = 1'b0;
    expect_out("release_start_high", 1, 0, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 0);
    check_out();
    expect_out("start_held", 1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0);
    check_out();
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
